axicb_qos_arbiter: RTL and testbench
====================================

# axicb_qos_arbiter

Parametrised, runtime-configurable QoS arbiter for the AXI crossbar switch ports. It selects one of REQ_NB requesters by runtime priority level, with round-robin inside a level and age-based anti-starvation promotion. It registers and holds the grant until the owning transaction signals completion. It replaces the fixed four-input, compile-time-priority round-robin arbiter in the crossbar's address-channel arbitration path.

## Interface
- REQ_NB, 8: number of requesters, 2..32
- PRIO_W, 2: priority field width per requester; 2^PRIO_W levels, higher value wins
- AGE_W, 4: width of the per-requester age counter
- AGE_MAX, 12: age value at which a requester becomes urgent; 0 disables aging; must be < 2^AGE_W
- aclk  in  1  clock, rising edge
- srst  in  1  synchronous active-high reset
- en  in  1  arbitration enable; low blocks new grants but does not revoke a held grant
- req  in  REQ_NB  request vector, one bit per requester
- prio  in  REQ_NB*PRIO_W  runtime priority; requester i uses bits [i*PRIO_W +: PRIO_W]
- done  in  1  single-cycle pulse: the current owner's transaction is complete
- grant  out  REQ_NB  registered one-hot grant
- grant_valid  out  1  high when grant is non-zero
- grant_idx  out  $clog2(REQ_NB)  binary index of the owner; valid when grant_valid

## Operation
- FSM states are IDLE and BUSY.
- IDLE: if en and |req, arbitrate; register the winner into grant, grant_idx and grant_valid; go to BUSY.
- BUSY: hold grant unchanged regardless of req, prio or en. On done, release.
  - If en and |req on that same cycle, re-arbitrate immediately and stay in BUSY with the new owner.
  - Otherwise clear grant and go to IDLE.
- done in IDLE is ignored.
- Arbitration proceeds in three steps:
  - Effective level = PRIO_W+1 bits: {urgent_i, prio_i}. urgent_i = (AGE_MAX != 0) && (age_i == AGE_MAX).
  - Find the highest effective level among asserted req bits.
  - Among requesters at that level, pick the first found scanning upward (mod REQ_NB) from last_idx+1.
- last_idx is a single pointer shared by all levels, loaded with the winner index on every grant.
- prio is sampled only on arbitration cycles. Changes while BUSY have no effect until the next arbitration.
- Age counter i, updated every cycle:
  - Clear when req_i is low, or when i wins arbitration.
  - Otherwise, if req_i and not owner, increment and saturate at AGE_MAX.
  - Counters advance even when en is low.
- With AGE_MAX=0, counters are held at 0 and the arbiter is pure priority + round-robin.
- With REQ_NB not a power of two, the scan wraps at REQ_NB-1 to 0. Indices ≥ REQ_NB never appear.

## Timing
- Reset values: grant=0, grant_valid=0, grant_idx=0, state=IDLE, all ages=0, last_idx=REQ_NB-1 (so requester 0 has first precedence).
- Latency: req sampled in IDLE at edge N gives grant at edge N+1 (one cycle).
- Handover: done at edge N with pending req gives the new grant at edge N+1, with zero idle cycles. The outgoing owner competes on that cycle but is last in rotation at its level.
- srst has priority over all inputs. Asserted mid-transaction, grant drops the following cycle with no done required.
- grant, grant_valid and grant_idx are all flops; no combinational path from req, prio or done to the outputs.
- Same-cycle events:
  - done with en low: release to IDLE.
  - req dropping on the done cycle: excluded from that arbitration.

## Test plan
- Reset, then req=8'h0F with all prio=0 and done pulsed every grant → grant_idx sequence 0,1,2,3,0, back-to-back with no IDLE cycles.
- req=8'h11, prio[4]=3, prio[0]=0, AGE_MAX=0 → requester 4 always wins. After req[4] drops and done, requester 0 is granted the next cycle.
- AGE_MAX=3; requester 1 at prio 0 held off by a continuous prio-3 stream from requesters 2/3, each holding 2 cycles → once age_1=3, requester 1 wins the next arbitration and age_1 clears.
- Owner 5 granted; change prio[5] and drop en for 4 cycles, then pulse done with en low → grant held unchanged throughout, then 0 with grant_valid=0 the cycle after done.
- srst asserted while BUSY with grant=8'h04 → next cycle grant=0, grant_idx=0, all ages 0. With req=8'hFF after reset, first grant is index 0.
- REQ_NB=5: req=5'b10001 with last_idx=4 → index 0 granted, then 4 after done (wrap check).

Source files
------------

// File: rtl/axicb_qos_arbiter.sv
// axicb_qos_arbiter
//   QoS arbiter for the crossbar address-channel path. Picks one of REQ_NB
//   requesters by runtime priority level. Ties inside a level are broken
//   round-robin from a single shared pointer. Requesters that wait AGE_MAX
//   cycles are promoted above every normal level. The grant is registered
//   and held until the owner pulses done.
//
// Ports
//   aclk        rising-edge clock
//   srst        synchronous active-high reset
//   en          arbitration enable (never revokes a held grant)
//   req         request vector, one bit per requester
//   prio        packed runtime priorities, requester i at [i*PRIO_W +: PRIO_W]
//   done        one-cycle pulse: current owner's transaction complete
//   grant       registered one-hot grant
//   grant_valid high while a grant is held
//   grant_idx   binary index of the owner, valid with grant_valid
module axicb_qos_arbiter #(
   parameter int unsigned REQ_NB  = 8,
   parameter int unsigned PRIO_W  = 2,
   parameter int unsigned AGE_W   = 4,
   parameter int unsigned AGE_MAX = 12
) (
   input  logic                       aclk,
   input  logic                       srst,
   input  logic                       en,
   input  logic [REQ_NB-1:0]          req,
   input  logic [REQ_NB*PRIO_W-1:0]   prio,
   input  logic                       done,
   output logic [REQ_NB-1:0]          grant,
   output logic                       grant_valid,
   output logic [$clog2(REQ_NB)-1:0]  grant_idx
);

   localparam int unsigned IDX_W = $clog2(REQ_NB);
   localparam int unsigned LVL_W = PRIO_W + 1;
   localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [AGE_W-1:0] age [REQ_NB];
   logic [IDX_W-1:0] last_idx;

   logic [LVL_W-1:0] lvl [REQ_NB];
   logic [LVL_W-1:0] top_lvl;
   logic [IDX_W-1:0] win_idx;
   logic             arb_fire;

   // Arbitrate from IDLE, or on the done cycle for a zero-gap handover.
   assign arb_fire = en && (|req) && ((state == IDLE) || done);

   // Effective level: urgency bit above the runtime priority field.
   always_comb begin
      for (int unsigned i = 0; i < REQ_NB; i++) begin
         lvl[i] = {(AGE_MAX != 0) && (age[i] == AGE_SAT), prio[i*PRIO_W +: PRIO_W]};
      end
   end

   always_comb begin
      top_lvl = '0;
      for (int unsigned i = 0; i < REQ_NB; i++) begin
         if (req[i] && (lvl[i] > top_lvl)) begin
            top_lvl = lvl[i];
         end
      end
   end

   // Rotating scan starting just after last_idx; the wrap is explicit so a
   // non-power-of-two REQ_NB never produces an out-of-range index.
   always_comb begin : scan
      int unsigned cand;
      logic        found;
      win_idx = last_idx;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned k = 1; k <= REQ_NB; k++) begin
         cand = 32'(last_idx) + k;
         if (cand >= REQ_NB) begin
            cand = cand - REQ_NB;
         end
         if (!found && req[cand] && (lvl[cand] == top_lvl)) begin
            found   = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         last_idx    <= IDX_W'(REQ_NB - 1);
         for (int unsigned i = 0; i < REQ_NB; i++) begin
            age[i] <= '0;
         end
      end else begin
         if (arb_fire) begin
            state       <= BUSY;
            grant       <= REQ_NB'(1) << win_idx;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            last_idx    <= win_idx;
         end else if ((state == BUSY) && done) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
         end

         // The owner's counter holds; waiting requesters age up to AGE_SAT.
         for (int unsigned i = 0; i < REQ_NB; i++) begin
            if (!req[i] || (arb_fire && (win_idx == IDX_W'(i)))) begin
               age[i] <= '0;
            end else if (!(grant_valid && (grant_idx == IDX_W'(i))) && (age[i] != AGE_SAT)) begin
               age[i] <= age[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axicb_qos_arbiter.sv
// tb_axicb_qos_arbiter
//   Drives three arbiter configurations (8 req / aging 12, 5 req / aging 3,
//   8 req / aging off) with shared control and requests, and compares every
//   output against a queue-free behavioural model each cycle.
module tb_axicb_qos_arbiter;

   logic        aclk = 1'b0;
   logic        srst, en, done;
   logic [7:0]  req_a;
   logic [15:0] prio_a;
   logic [4:0]  req_b;
   logic [9:0]  prio_b;

   logic [7:0]  g0, g2;
   logic [4:0]  g1;
   logic        v0, v1, v2;
   logic [2:0]  i0, i1, i2;

   logic [31:0] req_v;
   logic [1:0]  prio_v [32];

   int n_checks = 0;
   int n_pass   = 0;

   int n_cfg    [3] = '{8, 5, 8};
   int amax_cfg [3] = '{12, 3, 0};
   int m_age    [3][32];
   int m_last   [3];
   bit m_busy   [3];
   int m_idx    [3];

   always #5 aclk = ~aclk;

   axicb_qos_arbiter #(.REQ_NB(8), .PRIO_W(2), .AGE_W(4), .AGE_MAX(12)) u_a (
      .aclk(aclk), .srst(srst), .en(en), .req(req_a), .prio(prio_a), .done(done),
      .grant(g0), .grant_valid(v0), .grant_idx(i0));

   axicb_qos_arbiter #(.REQ_NB(5), .PRIO_W(2), .AGE_W(4), .AGE_MAX(3)) u_b (
      .aclk(aclk), .srst(srst), .en(en), .req(req_b), .prio(prio_b), .done(done),
      .grant(g1), .grant_valid(v1), .grant_idx(i1));

   axicb_qos_arbiter #(.REQ_NB(8), .PRIO_W(2), .AGE_W(4), .AGE_MAX(0)) u_c (
      .aclk(aclk), .srst(srst), .en(en), .req(req_a), .prio(prio_a), .done(done),
      .grant(g2), .grant_valid(v2), .grant_idx(i2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
   endtask

   function automatic int level(input int m, input int i);
      int u;
      u = (amax_cfg[m] != 0 && m_age[m][i] == amax_cfg[m]) ? 4 : 0;
      return u + int'(prio_v[i]);
   endfunction

   // Model: highest effective level wins, ties go to the first requester after
   // the last winner in circular order; ages count waiting cycles.
   task automatic model_step(input int m);
      int n, amax, best, win, idx;
      bit fire;
      n = n_cfg[m];
      amax = amax_cfg[m];
      if (srst) begin
         for (int i = 0; i < 32; i++) m_age[m][i] = 0;
         m_last[m] = n - 1;
         m_busy[m] = 0;
         m_idx[m]  = 0;
         return;
      end
      fire = en && ((req_v & ((32'd1 << n) - 1)) != 0) && (!m_busy[m] || done);
      best = -1;
      win  = -1;
      if (fire) begin
         for (int i = 0; i < n; i++)
            if (req_v[i] && level(m, i) > best) best = level(m, i);
         for (int k = 1; k <= n; k++) begin
            idx = (m_last[m] + k) % n;
            if (win < 0 && req_v[idx] && level(m, idx) == best) win = idx;
         end
      end
      for (int i = 0; i < n; i++) begin
         if (!req_v[i] || i == win) m_age[m][i] = 0;
         else if (!(m_busy[m] && m_idx[m] == i))
            m_age[m][i] = (m_age[m][i] + 1 > amax) ? amax : m_age[m][i] + 1;
      end
      if (fire) begin
         m_busy[m] = 1;
         m_idx[m]  = win;
         m_last[m] = win;
      end else if (m_busy[m] && done) begin
         m_busy[m] = 0;
         m_idx[m]  = 0;
      end
   endtask

   task automatic check_dut(input int m, input logic [7:0] g, input logic v, input logic [2:0] ix);
      logic [31:0] eg;
      eg = m_busy[m] ? (32'd1 << m_idx[m]) : 32'd0;
      check($sformatf("grant%0d", m), {24'd0, g}, eg);
      check($sformatf("valid%0d", m), {31'd0, v}, {31'd0, m_busy[m]});
      check($sformatf("idx%0d", m), {29'd0, ix}, 32'(m_idx[m]));
   endtask

   task automatic drive();
      req_a = req_v[7:0];
      req_b = req_v[4:0];
      for (int i = 0; i < 8; i++) prio_a[i*2 +: 2] = prio_v[i];
      for (int i = 0; i < 5; i++) prio_b[i*2 +: 2] = prio_v[i];
   endtask

   task automatic cycle();
      drive();
      @(posedge aclk);
      for (int m = 0; m < 3; m++) model_step(m);
      #1;
      check_dut(0, g0, v0, i0);
      check_dut(1, {3'd0, g1}, v1, i1);
      check_dut(2, g2, v2, i2);
   endtask

   initial begin
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 32; i++) m_age[m][i] = 0;
         m_last[m] = n_cfg[m] - 1;
         m_busy[m] = 0;
         m_idx[m]  = 0;
      end
      for (int i = 0; i < 32; i++) prio_v[i] = 2'd0;
      req_v = '0;
      srst  = 1'b1;
      en    = 1'b0;
      done  = 1'b0;
      repeat (2) cycle();
      srst = 1'b0;

      // Round-robin handover at equal priority, done every cycle.
      req_v = 32'h0F;
      en    = 1'b1;
      done  = 1'b1;
      repeat (6) cycle();
      done  = 1'b0;

      // Priority dominance, then hold with en low and prio changing.
      req_v = 32'h11;
      prio_v[4] = 2'd3;
      repeat (3) cycle();
      en = 1'b0;
      prio_v[4] = 2'd0;
      repeat (4) cycle();
      done = 1'b1;
      cycle();
      done = 1'b0;
      en = 1'b1;
      repeat (2) cycle();

      // Reset in the middle of a transaction, then full request.
      srst = 1'b1;
      cycle();
      srst = 1'b0;
      req_v = 32'hFF;
      repeat (3) cycle();

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         srst = ($urandom_range(0, 249) == 0);
         en   = ($urandom_range(0, 7) != 0);
         done = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) begin
            req_v = $urandom();
            if ($urandom_range(0, 1) == 0) req_v = req_v & $urandom();
         end
         if ($urandom_range(0, 7) == 0)
            for (int i = 0; i < 8; i++) prio_v[i] = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
